// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU with an iterative multiply/divide unit and HI/LO registers.
// Single-cycle ops answer one cycle after accept; MULT/MULTU/DIV/DIVU answer
// DATA_WIDTH+2 cycles after accept, holding in_ready low while busy.
// Build option: define ALU_MDU_DIV_EN to include the iterative divider; without
// it DIV/DIVU complete in one cycle with err=1 and leave HI/LO untouched.
module alu_mdu #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  err,
  output logic                  div0,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W = DATA_WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_MFLO = 4'd5,  OP_SLT  = 4'd6,  OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8,  OP_SRL  = 4'd9,  OP_SRA  = 4'd10, OP_MFHI = 4'd11;
  localparam logic [3:0] OP_MULT = 4'd12, OP_MULTU = 4'd13, OP_DIV = 4'd14, OP_DIVU = 4'd15;

`ifdef ALU_MDU_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIX = 2'd2, S_DIV = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIX = 2'd2} state_t;
`endif

  state_t               state_r, state_s;
  logic [SHAMT_W-1:0]   cnt_r;
  logic [2*W-1:0]       prod_r;       // {acc/rem, multiplier/quotient}
  logic [W-1:0]         mcand_r;      // multiplicand or divisor magnitude
  logic                 neg_r;        // negate product / quotient in FIX
  logic [W-1:0]         hi_r, lo_r, result_r;
  logic                 out_valid_r, zero_r, err_r, div0_r;
`ifdef ALU_MDU_DIV_EN
  logic                 is_div_r, negrem_r, dzero_r;
  logic [W-1:0]         a_r;
  logic                 is_div_s;
  logic [W:0]           div_top_s;
  logic [W+1:0]         div_diff_s;
  logic [2*W-1:0]       div_next_s;
`endif

  logic                 accept_s, signed_s, is_mul_s, err_s, last_s;
  logic [W-1:0]         a_mag_s, b_mag_s, alu_s, hi_fix_s, lo_fix_s;
  logic [W:0]           mul_sum_s;
  logic [2*W-1:0]       mul_next_s, prod_neg_s;

  assign in_ready  = (state_r == S_IDLE);
  assign busy      = (state_r != S_IDLE);
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;
  assign err       = err_r;
  assign div0      = div0_r;
  assign hi        = hi_r;
  assign lo        = lo_r;

  // Request decode, operand magnitudes and the single-cycle ALU.
  always_comb begin
    accept_s = in_valid && (state_r == S_IDLE);
    signed_s = (op == OP_MULT) || (op == OP_DIV);
    is_mul_s = (op == OP_MULT) || (op == OP_MULTU);
`ifdef ALU_MDU_DIV_EN
    is_div_s = (op == OP_DIV) || (op == OP_DIVU);
    err_s    = 1'b0;
`else
    err_s    = (op == OP_DIV) || (op == OP_DIVU);
`endif
    a_mag_s = (signed_s && a[W-1]) ? -a : a;
    b_mag_s = (signed_s && b[W-1]) ? -b : b;
    case (op)
      OP_ADD:  alu_s = a + b;
      OP_SUB:  alu_s = a - b;
      OP_AND:  alu_s = a & b;
      OP_OR:   alu_s = a | b;
      OP_XOR:  alu_s = a ^ b;
      OP_MFLO: alu_s = lo_r;
      OP_SLT:  alu_s = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_s = {{(W-1){1'b0}}, (a < b)};
      OP_SLL:  alu_s = a << b[SHAMT_W-1:0];
      OP_SRL:  alu_s = a >> b[SHAMT_W-1:0];
      OP_SRA:  alu_s = $unsigned($signed(a) >>> b[SHAMT_W-1:0]);
      OP_MFHI: alu_s = hi_r;
      default: alu_s = {W{1'b0}};
    endcase
  end

  // One shift-add / restoring-divide step and the FIX-stage sign correction.
  always_comb begin
    last_s     = (cnt_r == SHAMT_W'(W - 1));
    mul_sum_s  = {1'b0, prod_r[2*W-1:W]} + (prod_r[0] ? {1'b0, mcand_r} : {(W+1){1'b0}});
    mul_next_s = {mul_sum_s, prod_r[W-1:1]};
    prod_neg_s = neg_r ? -prod_r : prod_r;
    hi_fix_s   = prod_neg_s[2*W-1:W];
    lo_fix_s   = prod_neg_s[W-1:0];
`ifdef ALU_MDU_DIV_EN
    div_top_s  = prod_r[2*W-1:W-1];
    div_diff_s = {1'b0, div_top_s} - {2'b00, mcand_r};
    if (!div_diff_s[W+1]) begin
      div_next_s = {div_diff_s[W-1:0], prod_r[W-2:0], 1'b1};
    end else begin
      div_next_s = {div_top_s[W-1:0], prod_r[W-2:0], 1'b0};
    end
    if (is_div_r) begin
      if (dzero_r) begin
        lo_fix_s = {W{1'b1}};
        hi_fix_s = a_r;
      end else begin
        lo_fix_s = neg_r    ? -prod_r[W-1:0]     : prod_r[W-1:0];
        hi_fix_s = negrem_r ? -prod_r[2*W-1:W]   : prod_r[2*W-1:W];
      end
    end else begin
      lo_fix_s = prod_neg_s[W-1:0];
      hi_fix_s = prod_neg_s[2*W-1:W];
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state: IDLE -> MUL/DIV -> FIX -> IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s && is_mul_s) begin
          state_s = S_MUL;
`ifdef ALU_MDU_DIV_EN
        end else if (accept_s && is_div_s) begin
          state_s = S_DIV;
`endif
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MUL:   state_s = last_s ? S_FIX : S_MUL;
`ifdef ALU_MDU_DIV_EN
      S_DIV:   state_s = last_s ? S_FIX : S_DIV;
`endif
      S_FIX:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Datapath: operand load, iteration, HI/LO write-back and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {SHAMT_W{1'b0}};
      prod_r      <= {(2*W){1'b0}};
      mcand_r     <= {W{1'b0}};
      neg_r       <= 1'b0;
      hi_r        <= {W{1'b0}};
      lo_r        <= {W{1'b0}};
      result_r    <= {W{1'b0}};
      out_valid_r <= 1'b0;
      zero_r      <= 1'b0;
      err_r       <= 1'b0;
      div0_r      <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      is_div_r    <= 1'b0;
      negrem_r    <= 1'b0;
      dzero_r     <= 1'b0;
      a_r         <= {W{1'b0}};
`endif
    end else begin
      out_valid_r <= 1'b0;
      zero_r      <= 1'b0;
      err_r       <= 1'b0;
      div0_r      <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            cnt_r <= {SHAMT_W{1'b0}};
            neg_r <= signed_s && (a[W-1] ^ b[W-1]);
            if (is_mul_s) begin
              prod_r  <= {{W{1'b0}}, b_mag_s};
              mcand_r <= a_mag_s;
`ifdef ALU_MDU_DIV_EN
              is_div_r <= 1'b0;
            end else if (is_div_s) begin
              prod_r   <= {{W{1'b0}}, a_mag_s};
              mcand_r  <= b_mag_s;
              is_div_r <= 1'b1;
              negrem_r <= signed_s && a[W-1];
              dzero_r  <= (b == {W{1'b0}});
              a_r      <= a;
`endif
            end else begin
              out_valid_r <= 1'b1;
              result_r    <= alu_s;
              zero_r      <= (alu_s == {W{1'b0}});
              err_r       <= err_s;
            end
          end
        end
        S_MUL: begin
          prod_r <= mul_next_s;
          cnt_r  <= cnt_r + SHAMT_W'(1);
        end
`ifdef ALU_MDU_DIV_EN
        S_DIV: begin
          prod_r <= div_next_s;
          cnt_r  <= cnt_r + SHAMT_W'(1);
        end
`endif
        S_FIX: begin
          hi_r        <= hi_fix_s;
          lo_r        <= lo_fix_s;
          result_r    <= lo_fix_s;
          zero_r      <= (lo_fix_s == {W{1'b0}});
          out_valid_r <= 1'b1;
`ifdef ALU_MDU_DIV_EN
          div0_r      <= is_div_r && dzero_r;
`endif
        end
        default: begin
          cnt_r <= {SHAMT_W{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu (DATA_WIDTH=32); honours ALU_MDU_DIV_EN.
module tb_alu_mdu;
  localparam int W = 32;
`ifdef ALU_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = 32'd0, b = 32'd0;
  logic         in_ready, out_valid, zero, err, div0, busy;
  logic [W-1:0] result, hi, lo;

  alu_mdu #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .result(result),
    .zero(zero), .err(err), .div0(div0), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] res, hi, lo;
    logic         z, e, d0;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] hi_m = 32'd0, lo_m = 32'd0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, expv);
  endtask

  function automatic bit is_multi(input logic [3:0] o);
    return (o == 4'd12) || (o == 4'd13) || (DIV_EN && (o >= 4'd14));
  endfunction

  // Reference model; updates the model HI/LO for multi-cycle ops.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [63:0] p;
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.op = o; e.e = 1'b0; e.d0 = 1'b0; e.res = 32'd0;
    case (o)
      4'd0:  e.res = x + y;
      4'd1:  e.res = x - y;
      4'd2:  e.res = x & y;
      4'd3:  e.res = x | y;
      4'd4:  e.res = x ^ y;
      4'd5:  e.res = lo_m;
      4'd6:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd7:  e.res = (x < y) ? 32'd1 : 32'd0;
      4'd8:  e.res = x << y[4:0];
      4'd9:  e.res = x >> y[4:0];
      4'd10: e.res = $unsigned($signed(x) >>> y[4:0]);
      4'd11: e.res = hi_m;
      4'd12: begin p = 64'(sx * sy); hi_m = p[63:32]; lo_m = p[31:0]; e.res = lo_m; end
      4'd13: begin p = {32'd0, x} * {32'd0, y}; hi_m = p[63:32]; lo_m = p[31:0]; e.res = lo_m; end
      default: begin
        if (!DIV_EN) begin
          e.e = 1'b1;
        end else if (y == 32'd0) begin
          lo_m = 32'hFFFF_FFFF; hi_m = x; e.d0 = 1'b1; e.res = lo_m;
        end else if (o == 4'd14) begin
          p = 64'(sx / sy); lo_m = p[31:0];
          p = 64'(sx % sy); hi_m = p[31:0];
          e.res = lo_m;
        end else begin
          lo_m = x / y; hi_m = x % y; e.res = lo_m;
        end
      end
    endcase
    e.z = (e.res == 32'd0);
    e.hi = hi_m; e.lo = lo_m;
    return e;
  endfunction

  // Drive a request, wait (bounded) for acceptance and record the expectation.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int g;
    exp_t e;
    g = 0;
    in_valid = 1'b1; op = o; a = x; b = y;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1; g++;
    end
    if (!in_ready) begin
      check_val("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      e = model(o, x, y);
      e.cyc = cyc + (is_multi(o) ? W + 2 : 1);
      sb_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: pop and compare on every out_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_val($sformatf("op%0d_result", e.op), result, e.res);
          check_val($sformatf("op%0d_zero", e.op), W'(zero), W'(e.z));
          check_val($sformatf("op%0d_err", e.op), W'(err), W'(e.e));
          check_val($sformatf("op%0d_div0", e.op), W'(div0), W'(e.d0));
          check_val($sformatf("op%0d_hi", e.op), hi, e.hi);
          check_val($sformatf("op%0d_lo", e.op), lo, e.lo);
          check_val($sformatf("op%0d_cycle", e.op), W'(cyc), W'(e.cyc));
        end
      end else begin
        check_val("flags_idle", W'({zero, err, div0}), 32'd0);
      end
    end
  end

  initial begin
    int g;
    // Reset state
    #12;
    check_val("rst_out_valid", W'(out_valid), 32'd0);
    check_val("rst_result", result, 32'd0);
    check_val("rst_busy", W'(busy), 32'd0);
    check_val("rst_hilo", hi | lo, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    check_val("rst_in_ready", W'(in_ready), 32'd1);
    idle(2);

    // Directed single-cycle ops, back to back
    issue(4'd0, 32'h7FFF_FFFF, 32'd1);
    issue(4'd1, 32'd5, 32'd5);
    issue(4'd6, 32'hFFFF_FFFF, 32'd1);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    issue(4'd10, 32'h8000_0000, 32'h0000_001F);
    issue(4'd8, 32'd3, 32'h21);
    issue(4'd9, 32'h8000_0000, 32'd4);

    // MULT with busy timing, then MFHI/MFLO
    issue(4'd12, 32'hFFFF_FFFE, 32'd3);
    check_val("mult_busy_n1", W'({busy, in_ready}), 32'd2);
    idle(32);
    check_val("mult_busy_n33", W'(busy), 32'd1);
    idle(1);
    check_val("mult_done_n34", W'({busy, in_ready}), 32'd1);
    idle(1);
    issue(4'd11, 32'd0, 32'd0);
    issue(4'd5, 32'd0, 32'd0);

    // ADD held while busy, accepted on the completion cycle
    issue(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_val("held_in_ready", W'(in_ready), 32'd0);
    issue(4'd0, 32'd10, 32'd20);
    issue(4'd11, 32'd0, 32'd0);

    // Divide, or the unsupported-op path
    issue(4'd14, 32'hFFFF_FFF9, 32'd2);
    issue(4'd15, 32'd7, 32'd0);
    issue(4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(4'd14, 32'd7, 32'hFFFF_FFFE);
    issue(4'd15, 32'd100, 32'd7);
    issue(4'd11, 32'd0, 32'd0);

    // Random single- and multi-cycle traffic
    for (int i = 0; i < 24; i++) begin
      issue(4'($urandom_range(0, 11)), $urandom, $urandom);
    end
    for (int i = 0; i < 6; i++) begin
      issue(4'($urandom_range(12, 15)), $urandom, (i == 5) ? 32'd0 : 32'($urandom_range(0, 1000)) - 32'd500);
      issue(4'd11, 32'd0, 32'd0);
    end
    issue(4'd5, 32'd0, 32'd0);

    // Reset in the middle of a MULTU
    idle(3);
    issue(4'd13, 32'h1234_5678, 32'h9ABC_DEF0);
    idle(9);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    hi_m = 32'd0; lo_m = 32'd0;
    check_val("midrst_busy", W'({busy, out_valid}), 32'd0);
    check_val("midrst_hilo", hi | lo, 32'd0);
    check_val("midrst_result", result, 32'd0);
    idle(2);
    rst_n = 1'b1;
    check_val("midrst_in_ready", W'(in_ready), 32'd1);
    issue(4'd11, 32'd0, 32'd0);
    issue(4'd14, 32'd9, 32'd3);
    issue(4'd4, 32'hA5A5_A5A5, 32'hFFFF_0000);

    // Drain the scoreboard (bounded)
    g = 0;
    while (sb_q.size() != 0 && g < 200) begin
      @(posedge clk); g++;
    end
    #1;
    check_val("drain", W'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
